// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a wait-state request/ready handshake.
// Requests are latched in IDLE, commit on the edge entering DONE, and report misalignment.
module data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    logic [31:0]             mem_q [Depth];
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    commit;
    logic                    misaligned;
    logic                    unused_addr;

    // Upper address bits only alias; fold them so lint sees them consumed.
    assign unused_addr = ^addr_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (ce_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[ADDR_WIDTH+1:0];
                    wdata_d = wdata_i;
                    cnt_d   = WaitInit;
                    state_d = (WAIT_CYCLES == 0) ? StDone : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rst) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end
    end

    // The *_d request fields hold either the freshly sampled inputs (zero wait
    // states) or the latched request, so commit logic can use them uniformly.
    assign idx        = addr_d[ADDR_WIDTH+1:2];
    assign misaligned = (addr_d[1:0] != 2'b00);
    assign commit     = (state_d == StDone) && (state_q != StDone);

    always_comb begin
        rdata_d = rdata_q;
        ready_d = commit;
        err_d   = commit && misaligned;
        busy_d  = (state_d != StIdle);
        if (commit && misaligned) begin
            rdata_d = 32'h0;
        end else if (commit && !we_d) begin
            rdata_d = mem_q[idx];
        end
        if (rst) begin
            rdata_d = 32'h0;
            ready_d = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        ready_q <= ready_d;
        err_q   <= err_d;
        busy_q  <= busy_d;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit && we_d && !misaligned) begin
            mem_q[idx] <= wdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances with 0, 1 and 3 wait states.
module tb_data_mem_ctrl;

    localparam int unsigned WC [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t expq [3][$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(
            .ADDR_WIDTH (10),
            .WAIT_CYCLES(WC[g])
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .ce_i   (ce[g]),
            .we_i   (we[g]),
            .addr_i (addr[g]),
            .wdata_i(wdata[g]),
            .rdata_o(rdata[g]),
            .ready_o(ready[g]),
            .err_o  (err[g]),
            .busy_o (busy[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (ready[i] === 1'b1) begin
                    if (expq[i].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_ready", i), 32'd1, 32'd0);
                    end else begin
                        e = expq[i].pop_front();
                        check($sformatf("dut%0d_err", i), {31'd0, err[i]}, {31'd0, e.err});
                        check($sformatf("dut%0d_busy_in_done", i), {31'd0, busy[i]}, 32'd1);
                        if (e.chk) begin
                            check($sformatf("dut%0d_rdata", i), rdata[i], e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic access(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_e, input logic chk, input logic scramble);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        ce[i]    = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        expq[i].push_back('{rdata: exp_rd, err: exp_e, chk: chk});
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready[i] === 1'b1) begin
                seen = 1'b1;
            end else if (scramble) begin
                addr[i]  = ~a;
                wdata[i] = ~d;
            end
        end
        if (!seen) begin
            check($sformatf("dut%0d_timeout", i), 32'd0, 32'd1);
        end else begin
            check($sformatf("dut%0d_latency", i), lat, WC[i] + 1);
        end
        @(negedge clk);
        ce[i] = 1'b0;
    endtask

    task automatic back_to_back(input int i, input logic [31:0] a, input logic [31:0] exp_rd,
                                input int n);
        int pulses;
        int last;
        pulses = 0;
        last   = 0;
        for (int k = 0; k < n; k++) begin
            expq[i].push_back('{rdata: exp_rd, err: 1'b0, chk: 1'b1});
        end
        @(negedge clk);
        ce[i]   = 1'b1;
        we[i]   = 1'b0;
        addr[i] = a;
        for (int k = 0; k < 60 && pulses < n; k++) begin
            @(posedge clk);
            #1;
            if (ready[i] === 1'b1) begin
                if (pulses > 0) begin
                    check($sformatf("dut%0d_b2b_period", i), cyc - last, WC[i] + 2);
                end
                last = cyc;
                pulses++;
            end
        end
        @(negedge clk);
        ce[i] = 1'b0;
        check($sformatf("dut%0d_b2b_pulses", i), pulses, n);
    endtask

    task automatic reset_mid_access();
        int pulses;
        pulses = 0;
        @(negedge clk);
        ce[2]    = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h20;
        wdata[2] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        // Reset lands on the edge ending the second WAIT cycle.
        @(negedge clk);
        rst   = 1'b1;
        ce[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (ready[2] === 1'b1) pulses++;
        end
        check("reset_mid_no_ready", pulses, 0);
        check("reset_mid_busy", {31'd0, busy[2]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            ce[i]    = 1'b1;
            we[i]    = 1'b1;
            addr[i]  = 32'h0;
            wdata[i] = 32'h1357_9BDF;
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
                check($sformatf("rst_ready%0d", i), {31'd0, ready[i]}, 32'd0);
                check($sformatf("rst_busy%0d", i), {31'd0, busy[i]}, 32'd0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) ce[i] = 1'b0;

        // One wait state: store/load, misalignment, aliasing.
        access(1, 1'b1, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        access(1, 1'b1, 32'h14,   32'h1111_2222, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        access(1, 1'b1, 32'h13,   32'h1234_5678, 32'h0,         1'b1, 1'b0, 1'b0);
        access(1, 1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h13,   32'h0,         32'h0,         1'b1, 1'b1, 1'b0);
        access(1, 1'b1, 32'h1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h0,    32'h0,         32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h14,   32'h0,         32'h1111_2222, 1'b0, 1'b1, 1'b0);

        // Zero wait states.
        access(0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b1, 1'b0);
        access(0, 1'b0, 32'h40, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
        back_to_back(0, 32'h40, 32'hCAFE_F00D, 3);

        // Three wait states, with inputs disturbed mid-access.
        access(2, 1'b1, 32'h20, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0);
        access(2, 1'b1, 32'h24, 32'h55AA_55AA, 32'h0,         1'b0, 1'b1, 1'b0);
        access(2, 1'b0, 32'h24, 32'h0,         32'h55AA_55AA, 1'b0, 1'b1, 1'b1);
        access(2, 1'b1, 32'h28, 32'h0BAD_C0DE, 32'h55AA_55AA, 1'b0, 1'b1, 1'b1);
        access(2, 1'b0, 32'h28, 32'h0,         32'h0BAD_C0DE, 1'b0, 1'b1, 1'b0);
        back_to_back(2, 32'h24, 32'h55AA_55AA, 3);

        reset_mid_access();
        access(2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_queue_drained", i), expq[i].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
